// File: rtl/sti_pkg.sv
// Shared types and helpers for the STI serializer scheduler.
//   state_e  : scheduler FSM states
//   cfg_t    : per-word serializer format {fill, msb, low, length}
//   LEN_*    : length field encodings
//   sti_bits : number of bits shifted for a given length code
package sti_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_END,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       fill;
    logic       msb;
    logic       low;
    logic [1:0] length;
  } cfg_t;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // Upper bound on channel count; cur_ch is 3 bits wide.
  localparam int unsigned MAX_NCH = 8;

  // Bits in one transfer: 8 * (length + 1), i.e. 8/16/24/32.
  function automatic logic [5:0] sti_bits(input logic [1:0] length);
    return {({1'b0, length} + 3'd1), 3'b000};
  endfunction

endpackage

// File: rtl/sti_sched_if.sv
// Bundle between the packet sources / serializer side and the scheduler.
//   Requester side : req, data, cfg, last (to scheduler), ack (from scheduler)
//   Serializer side: load, pi_data, pi_fill, pi_msb, pi_low, pi_length, pi_end
//   Status         : busy, cur_ch, done
// Channel k occupies data[k] (= flat bits [16k+15:16k]) and cfg[k]
// (= flat bits [5k+4:5k]).
//   master : drives requests, observes grants/serializer strobes
//   slave  : the scheduler
interface sti_sched_if #(
  parameter int unsigned NCH = 2
);
  import sti_pkg::*;

  logic [NCH-1:0]       req;
  logic [NCH-1:0][15:0] data;
  cfg_t [NCH-1:0]       cfg;
  logic [NCH-1:0]       last;
  logic [NCH-1:0]       ack;

  logic                 load;
  logic [15:0]          pi_data;
  logic                 pi_fill;
  logic                 pi_msb;
  logic                 pi_low;
  logic [1:0]           pi_length;
  logic                 pi_end;

  logic                 busy;
  logic [2:0]           cur_ch;
  logic                 done;

  modport master (
    output req, data, cfg, last,
    input  ack, load, pi_data, pi_fill, pi_msb, pi_low, pi_length, pi_end,
           busy, cur_ch, done
  );

  modport slave (
    input  req, data, cfg, last,
    output ack, load, pi_data, pi_fill, pi_msb, pi_low, pi_length, pi_end,
           busy, cur_ch, done
  );

endinterface

// File: rtl/sti_rr_arb.sv
// Round-robin picker for the STI scheduler.
//   eligible : channels that may be granted this cycle
//   grant_en : commit the current pick; advances the pointer past it
//   grant    : index of the picked channel (valid only when valid=1)
//   valid    : at least one channel is eligible
// The pick is combinational so simultaneous requests resolve in the same
// cycle; only the pointer is registered.
module sti_rr_arb #(
  parameter int unsigned NCH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] eligible,
  input  logic           grant_en,
  output logic [2:0]     grant,
  output logic           valid
);

  logic [2:0] ptr;
  logic [2:0] hi_grant;
  logic [2:0] lo_grant;
  logic       hi_valid;
  logic       lo_valid;

  // Two searches: the first eligible channel at or above the pointer, and
  // the first eligible channel overall (used when the first one wraps).
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the unassigned path infers a latch.
  always_comb begin
    hi_grant = '0;
    hi_valid = 1'b0;
    lo_grant = '0;
    lo_valid = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      if (eligible[j] && !lo_valid) begin
        lo_valid = 1'b1;
        lo_grant = 3'(j);
      end
      if (eligible[j] && !hi_valid && (3'(j) >= ptr)) begin
        hi_valid = 1'b1;
        hi_grant = 3'(j);
      end
    end
  end

  // Any hit above the pointer is also a hit overall.
  assign valid = lo_valid;
  assign grant = hi_valid ? hi_grant : lo_grant;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= (grant == 3'(NCH - 1)) ? 3'd0 : grant + 3'd1;
    end
  end

endmodule

// File: rtl/sti_sched.sv
// Round-robin scheduler sharing one STI parallel-to-serial converter
// between NCH requesters.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : requester words/format in, ack out; serializer load, word,
//            format and end-of-stream strobe out; busy/cur_ch/done status
// One word per grant: capture in IDLE, one-cycle LOAD (load + ack), then
// SHIFT for the programmed length. Once every channel has delivered its
// last word, pi_end pulses once and the block parks in DONE until reset.
// The serializer downstream is reset from the inverse of rst_n in the same
// cycle, so both sides leave reset together.
module sti_sched
  import sti_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sti_sched_if.slave     bus
);

  state_e                    state;
  logic [5:0]                cnt;
  logic                      tail;
  logic [NCH-1:0]            ended;
  logic                      last_q;
  logic [2:0]                cur_ch_q;
  logic                      load_q;
  logic [NCH-1:0]            ack_q;
  logic [15:0]               pi_data_q;
  cfg_t                      pi_cfg_q;
  logic                      pi_end_q;
  logic                      done_q;

  logic [MAX_NCH-1:0][15:0]  data_pad;
  cfg_t [MAX_NCH-1:0]        cfg_pad;
  logic [MAX_NCH-1:0]        last_pad;
  logic [NCH-1:0]            grant_onehot;
  logic [NCH-1:0]            cur_onehot;

  logic [NCH-1:0]            eligible;
  logic                      all_ended;
  logic                      grant_en;
  logic [2:0]                grant;
  logic                      grant_valid;

  // Widen the per-channel inputs to MAX_NCH entries so a 3-bit index
  // selects without width mismatch for any NCH.
  always_comb begin
    data_pad = '0;
    cfg_pad  = '0;
    last_pad = '0;
    for (int k = 0; k < NCH; k++) begin
      data_pad[k] = bus.data[k];
      cfg_pad[k]  = bus.cfg[k];
      last_pad[k] = bus.last[k];
    end
  end

  always_comb begin
    grant_onehot = '0;
    cur_onehot   = '0;
    for (int k = 0; k < NCH; k++) begin
      grant_onehot[k] = (grant == 3'(k));
      cur_onehot[k]   = (cur_ch_q == 3'(k));
    end
  end

  // Channels that have delivered their last word drop out of arbitration.
  assign eligible  = bus.req & ~ended;
  assign all_ended = &ended;
  assign grant_en  = (state == ST_IDLE) && !all_ended && grant_valid;

  sti_rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant_en (grant_en),
    .grant    (grant),
    .valid    (grant_valid)
  );

  // SHIFT walks the counter from N-1 down to 0, then spends one more
  // cycle (tail) while the serializer clocks out the final bit, so the
  // serializer is already idle when the FSM is back in IDLE.
  // NOTE: the pi_* capture registers are reset along with the control
  // state because the serializer inputs must read zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tail      <= 1'b0;
      ended     <= '0;
      last_q    <= 1'b0;
      cur_ch_q  <= '0;
      load_q    <= 1'b0;
      ack_q     <= '0;
      pi_data_q <= '0;
      pi_cfg_q  <= '0;
      pi_end_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      load_q   <= 1'b0;
      ack_q    <= '0;
      pi_end_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (all_ended) begin
            pi_end_q <= 1'b1;
            state    <= ST_END;
          end else if (grant_valid) begin
            pi_data_q <= data_pad[grant];
            pi_cfg_q  <= cfg_pad[grant];
            last_q    <= last_pad[grant];
            cur_ch_q  <= grant;
            load_q    <= 1'b1;
            ack_q     <= grant_onehot;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= sti_bits(pi_cfg_q.length) - 6'd1;
          tail  <= 1'b0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
          end else if (!tail) begin
            tail <= 1'b1;
          end else begin
            tail  <= 1'b0;
            state <= ST_IDLE;
            if (last_q) begin
              ended <= ended | cur_onehot;
            end
          end
        end
        ST_END: begin
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.load      = load_q;
  assign bus.ack       = ack_q;
  assign bus.pi_data   = pi_data_q;
  assign bus.pi_fill   = pi_cfg_q.fill;
  assign bus.pi_msb    = pi_cfg_q.msb;
  assign bus.pi_low    = pi_cfg_q.low;
  assign bus.pi_length = pi_cfg_q.length;
  assign bus.pi_end    = pi_end_q;
  assign bus.cur_ch    = cur_ch_q;
  assign bus.done      = done_q;

  // The capturing IDLE cycle counts as busy; no capture happens under reset.
  assign bus.busy = rst_n &&
                    ((state == ST_LOAD) || (state == ST_SHIFT) || grant_en);

  // Grants are one-hot and the serializer word never moves mid-transfer.
  a_ack_onehot : assert property (
    @(posedge clk) disable iff (!rst_n) bus.load |-> $onehot(bus.ack)
  );

  a_pi_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
      (state == ST_SHIFT) |-> $stable({pi_data_q, pi_cfg_q})
  );

endmodule

// File: tb/tb_sti_sched.sv
// Directed bench for sti_sched with NCH=2. Inputs change and outputs are
// sampled on the falling edge; expected values are hand-computed from the
// transfer timing (load-to-load = N+3, busy from load = N+2 cycles).
module tb_sti_sched;
  import sti_pkg::*;

  localparam int unsigned NCH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  sti_sched_if #(.NCH(NCH)) bus ();

  sti_sched #(.NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic [15:0] d;
    int          exp_busy;
  } vec_t;

  vec_t len_vec [4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [15:0] d, input logic fill,
                        input logic msb, input logic low,
                        input logic [1:0] len, input logic lst);
    cfg_t c;
    c.fill   = fill;
    c.msb    = msb;
    c.low    = low;
    c.length = len;
    bus.data[ch] = d;
    bus.cfg[ch]  = c;
    bus.last[ch] = lst;
  endtask

  function automatic logic [20:0] pi_bundle();
    return {bus.pi_data, bus.pi_fill, bus.pi_msb, bus.pi_low, bus.pi_length};
  endfunction

  task automatic wait_load(input string tag, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (bus.load) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Called on the load cycle: counts busy cycles and checks the serializer
  // word stays put through the shift and in the following IDLE.
  task automatic measure_busy(output int n, output logic stable);
    logic [20:0] ref_v;
    ref_v  = pi_bundle();
    n      = 0;
    stable = 1'b1;
    while (bus.busy && n < 100) begin
      n++;
      if (pi_bundle() !== ref_v) stable = 1'b0;
      step();
    end
    if (pi_bundle() !== ref_v) stable = 1'b0;
  endtask

  initial begin
    int   l1, l2, at, prev, n;
    int   pe_cnt, pe_at, ld_cnt, ack_cnt;
    logic stable;

    len_vec[0] = '{0, LEN_8,  1'b1, 1'b0, 1'b1, 16'h00FF, 10};
    len_vec[1] = '{1, LEN_16, 1'b0, 1'b1, 1'b0, 16'hA5C3, 18};
    len_vec[2] = '{0, LEN_24, 1'b1, 1'b1, 1'b1, 16'h1357, 26};
    len_vec[3] = '{1, LEN_32, 1'b0, 1'b0, 1'b0, 16'hFFFF, 34};

    bus.req  = '0;
    bus.data = '0;
    bus.cfg  = '0;
    bus.last = '0;

    // Reset state
    step();
    step();
    check("rst_load",   bus.load,    1'b0);
    check("rst_ack",    bus.ack,     2'b00);
    check("rst_busy",   bus.busy,    1'b0);
    check("rst_pidata", bus.pi_data, 16'h0000);
    check("rst_piend",  bus.pi_end,  1'b0);
    check("rst_done",   bus.done,    1'b0);
    rst_n = 1'b1;
    step();

    // Single channel: 16-bit word, req held, next word queued behind it
    set_ch(0, 16'hA5C3, 1'b0, 1'b1, 1'b0, LEN_16, 1'b0);
    bus.req = 2'b01;
    #1;
    check("single_capture_busy", bus.busy, 1'b1);
    step();
    check("single_load", bus.load, 1'b1);
    check("single_ack", bus.ack, 2'b01);
    check("single_pidata", bus.pi_data, 16'hA5C3);
    check("single_msb", bus.pi_msb, 1'b1);
    check("single_len", bus.pi_length, LEN_16);
    check("single_curch", bus.cur_ch, 3'd0);
    l1 = cyc;
    set_ch(0, 16'h1234, 1'b0, 1'b0, 1'b0, LEN_8, 1'b0);
    stable = 1'b1;
    l2 = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.load) begin
        l2 = cyc;
        break;
      end
      if (bus.pi_data !== 16'hA5C3 || bus.pi_msb !== 1'b1 ||
          bus.pi_length !== LEN_16) stable = 1'b0;
    end
    check("single_pi_stable", stable, 1'b1);
    check("single_gap", l2 - l1, 19);
    check("single_second_word", bus.pi_data, 16'h1234);
    bus.req = '0;
    measure_busy(n, stable);
    check("single_len8_busy", n, 10);

    // Length coverage with fill toggled
    for (int i = 0; i < 4; i++) begin
      set_ch(len_vec[i].ch, len_vec[i].d, len_vec[i].fill, len_vec[i].msb,
             len_vec[i].low, len_vec[i].len, 1'b0);
      bus.req = '0;
      bus.req[len_vec[i].ch] = 1'b1;
      wait_load("len_load", 20, at);
      bus.req = '0;
      check("len_ack", bus.ack, (len_vec[i].ch == 0) ? 2'b01 : 2'b10);
      check("len_fill", bus.pi_fill, len_vec[i].fill);
      check("len_pidata", bus.pi_data, len_vec[i].d);
      measure_busy(n, stable);
      check("len_busy_cycles", n, len_vec[i].exp_busy);
      check("len_pi_stable", stable, 1'b1);
    end

    // Contention: both channels, 8-bit words, acks alternate 0,1,0,1
    set_ch(0, 16'h0F0F, 1'b0, 1'b0, 1'b0, LEN_8, 1'b0);
    set_ch(1, 16'hF0F0, 1'b0, 1'b0, 1'b0, LEN_8, 1'b0);
    bus.req = 2'b11;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_load("cont_load", 20, at);
      check("cont_ack", bus.ack, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("cont_pidata", bus.pi_data, (k % 2 == 0) ? 16'h0F0F : 16'hF0F0);
      if (k > 0) check("cont_gap", at - prev, 11);
      prev = at;
    end
    bus.req = '0;
    measure_busy(n, stable);
    check("cont_last_busy", n, 10);

    // Dropped request: req high for the capture cycle only
    set_ch(1, 16'h5AA5, 1'b1, 1'b0, 1'b1, LEN_16, 1'b0);
    bus.req = 2'b10;
    step();
    bus.req = '0;
    check("drop_load", bus.load, 1'b1);
    check("drop_ack", bus.ack, 2'b10);
    check("drop_pidata", bus.pi_data, 16'h5AA5);
    measure_busy(n, stable);
    check("drop_busy_cycles", n, 18);
    check("drop_pi_stable", stable, 1'b1);

    // Reset in the middle of a 32-bit transfer from ch0 (pointer -> 1)
    set_ch(0, 16'hBEEF, 1'b1, 1'b1, 1'b1, LEN_32, 1'b0);
    bus.req = 2'b01;
    wait_load("rst_mid_load", 20, at);
    bus.req = '0;
    check("rst_mid_ack", bus.ack, 2'b01);
    repeat (10) step();
    check("rst_mid_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    step();
    check("rst_mid_load0", bus.load, 1'b0);
    check("rst_mid_busy0", bus.busy, 1'b0);
    check("rst_mid_pidata0", bus.pi_data, 16'h0000);
    check("rst_mid_cfg0",
          {bus.pi_fill, bus.pi_msb, bus.pi_low, bus.pi_length}, 5'b00000);
    check("rst_mid_curch0", bus.cur_ch, 3'd0);
    rst_n = 1'b1;
    set_ch(0, 16'h0001, 1'b0, 1'b0, 1'b0, LEN_8, 1'b0);
    set_ch(1, 16'h0002, 1'b0, 1'b0, 1'b0, LEN_8, 1'b0);
    bus.req = 2'b11;
    wait_load("rst_ptr_load", 20, at);
    bus.req = '0;
    check("rst_ptr_ack", bus.ack, 2'b01);
    measure_busy(n, stable);
    check("rst_ptr_busy", n, 10);

    // End of stream: ch1 last, ch0 non-last, then ch0 last
    set_ch(0, 16'h00A0, 1'b0, 1'b0, 1'b0, LEN_8, 1'b0);
    set_ch(1, 16'h00B1, 1'b0, 1'b0, 1'b0, LEN_8, 1'b1);
    bus.req = 2'b11;
    wait_load("eos_load1", 20, at);
    check("eos_ack1", bus.ack, 2'b10);
    prev = at;
    wait_load("eos_load2", 20, at);
    check("eos_ack2", bus.ack, 2'b01);
    check("eos_gap2", at - prev, 11);
    set_ch(0, 16'h00A1, 1'b0, 1'b0, 1'b0, LEN_8, 1'b1);
    prev = at;
    wait_load("eos_load3", 20, at);
    check("eos_ack3_ch1_excluded", bus.ack, 2'b01);
    check("eos_gap3", at - prev, 11);
    pe_cnt = 0;
    pe_at  = -1;
    ld_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.pi_end) begin
        pe_cnt++;
        if (pe_at < 0) pe_at = cyc;
      end
      if (bus.load) ld_cnt++;
    end
    check("eos_piend_count", pe_cnt, 1);
    check("eos_piend_time", pe_at - at, 11);
    check("eos_no_more_loads", ld_cnt, 0);
    check("eos_done", bus.done, 1'b1);
    check("eos_busy", bus.busy, 1'b0);
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (|bus.ack) ack_cnt++;
    end
    check("done_no_ack", ack_cnt, 0);
    check("done_held", bus.done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
